// File: rtl/mult_pkg.sv
// Width constants for the gated 16x16 exact multiplier.
package mult_pkg;

   localparam int unsigned OPND_W = 16;
   localparam int unsigned PROD_W = 32;

endpackage : mult_pkg

// File: rtl/clock_gate_icg.sv
// Latch-based integrated clock gate: enable is captured while clk is low,
// so gclk only ever passes complete clk high phases.
module clock_gate_icg (
   input  logic clk,
   input  logic en,
   output logic gclk
);

   logic en_lat;

   // Transparent low; the latch has no reset, its first low phase defines it.
   always_latch begin
      if (!clk) en_lat <= en;
   end

   assign gclk = clk & en_lat;

endmodule : clock_gate_icg

// File: rtl/clock_gated_exact_mult_16bit.sv
// Exact unsigned NxN array multiplier with a registered product on a gated clock.
// The gate is opened by en or rst so synchronous reset still reaches Y.
module clock_gated_exact_mult_16bit
   import mult_pkg::*;
#(
   parameter int unsigned N = OPND_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [N-1:0]     A,
   input  logic [N-1:0]     B,
   output logic [2*N-1:0]   Y
);

   localparam int unsigned PW = 2 * N;

   logic          gate_en;
   logic          gclk;
   logic [PW-1:0] prod;
   logic [PW-1:0] y_q;

   assign gate_en = en | rst;

   clock_gate_icg u_icg (
      .clk  (clk),
      .en   (gate_en),
      .gclk (gclk)
   );

   // AND-gate partial products accumulated row by row through ripple full adders.
   always_comb begin : mul_array
      logic [PW-1:0] acc;
      logic [PW-1:0] row;
      logic          c;
      logic          s;
      acc = '0;
      row = '0;
      c   = 1'b0;
      s   = 1'b0;
      for (int i = 0; i < int'(N); i++) begin
         row = '0;
         for (int j = 0; j < int'(N); j++) begin
            row[i+j] = A[j] & B[i];
         end
         c = 1'b0;
         for (int k = 0; k < int'(PW); k++) begin
            s      = acc[k] ^ row[k] ^ c;
            c      = (acc[k] & row[k]) | (c & (acc[k] ^ row[k]));
            acc[k] = s;
         end
      end
      prod = acc;
   end

   // Only enabled (or reset) edges reach this register through the gate.
   always_ff @(posedge gclk) begin
      if (rst) y_q <= '0;
      else     y_q <= prod;
   end

   assign Y = y_q;

endmodule : clock_gated_exact_mult_16bit

// File: tb/tb_clock_gated_exact_mult_16bit.sv
// Bench for clock_gated_exact_mult_16bit: directed table, gate-timing sequences,
// and randomized operands against an arithmetic reference model.
module tb_clock_gated_exact_mult_16bit;
   import mult_pkg::*;

   logic                clk;
   logic                rst;
   logic                en;
   logic [OPND_W-1:0]   a_s;
   logic [OPND_W-1:0]   b_s;
   logic [PROD_W-1:0]   y;

   int unsigned n_vec;
   int unsigned n_err;
   int unsigned gclk_cnt;

   clock_gated_exact_mult_16bit #(.N(OPND_W)) dut (
      .clk (clk),
      .rst (rst),
      .en  (en),
      .A   (a_s),
      .B   (b_s),
      .Y   (y)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge dut.gclk) gclk_cnt++;

   typedef struct {
      logic              r;
      logic              e;
      logic [15:0]       a;
      logic [15:0]       b;
      logic [31:0]       exp;
   } vec_t;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, want %h", nm, act, exp);
      end
   endtask

   task automatic drive(input logic r, input logic e, input logic [15:0] a, input logic [15:0] b);
      @(negedge clk);
      rst = r;
      en  = e;
      a_s = a;
      b_s = b;
   endtask

   // Advance one rising edge and settle past it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   vec_t        vecs[14];
   logic [31:0] model;
   int unsigned cnt0;
   logic        r_r;
   logic        e_r;
   logic [15:0] a_r;
   logic [15:0] b_r;
   logic [63:0] full;

   initial begin
      n_vec    = 0;
      n_err    = 0;
      gclk_cnt = 0;
      rst      = 1'b0;
      en       = 1'b0;
      a_s      = '0;
      b_s      = '0;

      vecs[0]  = '{1'b1, 1'b0, 16'd0,     16'd0,     32'd0};
      vecs[1]  = '{1'b0, 1'b0, 16'd0,     16'd0,     32'd0};
      vecs[2]  = '{1'b0, 1'b1, 16'd20,    16'd10,    32'd200};
      vecs[3]  = '{1'b0, 1'b1, 16'd100,   16'd25,    32'd2500};
      vecs[4]  = '{1'b0, 1'b1, 16'd1024,  16'd8,     32'd8192};
      vecs[5]  = '{1'b0, 1'b1, 16'd5000,  16'd3000,  32'd15000000};
      vecs[6]  = '{1'b0, 1'b0, 16'hFFFF,  16'hFFFF,  32'd15000000};
      vecs[7]  = '{1'b0, 1'b0, 16'hFFFF,  16'hFFFF,  32'd15000000};
      vecs[8]  = '{1'b0, 1'b1, 16'd15,    16'd15,    32'd225};
      vecs[9]  = '{1'b0, 1'b1, 16'hFFFF,  16'hFFFF,  32'hFFFE_0001};
      vecs[10] = '{1'b1, 1'b1, 16'hFFFF,  16'hFFFF,  32'd0};
      vecs[11] = '{1'b0, 1'b1, 16'd0,     16'd1234,  32'd0};
      vecs[12] = '{1'b0, 1'b1, 16'd1,     16'hFFFF,  32'h0000_FFFF};
      vecs[13] = '{1'b0, 1'b1, 16'hABCD,  16'd0,     32'd0};

      for (int i = 0; i < 14; i++) begin
         drive(vecs[i].r, vecs[i].e, vecs[i].a, vecs[i].b);
         cnt0 = gclk_cnt;
         step();
         check($sformatf("vec%0d_y", i), y, vecs[i].exp);
         if (!vecs[i].r && !vecs[i].e)
            check($sformatf("vec%0d_gclk_pulses", i), 32'(gclk_cnt - cnt0), 32'd0);
      end

      // en rising while clk is high must not open the gate in that phase.
      drive(1'b0, 1'b0, 16'd3, 16'd7);
      step();
      cnt0 = gclk_cnt;
      en   = 1'b1;
      #2;
      check("late_rise_gclk_level", 32'(dut.gclk), 32'd0);
      check("late_rise_no_pulse", 32'(gclk_cnt - cnt0), 32'd0);
      check("late_rise_hold", y, 32'd0);
      step();
      check("late_rise_capture", y, 32'd21);

      // en falling while clk is high must not truncate the running pulse.
      drive(1'b0, 1'b1, 16'd9, 16'd9);
      step();
      en  = 1'b0;
      a_s = 16'd2;
      #2;
      check("early_fall_gclk_level", 32'(dut.gclk), 32'd1);
      check("early_fall_capture", y, 32'd81);
      step();
      check("early_fall_hold", y, 32'd81);

      // Randomized capture/hold/reset against plain arithmetic.
      model = 32'd81;
      for (int i = 0; i < 1000; i++) begin
         r_r = ($urandom_range(0, 31) == 0);
         e_r = 1'($urandom_range(0, 1));
         a_r = 16'($urandom);
         b_r = 16'($urandom);
         if (i % 50 == 0) a_r = 16'hFFFF;
         drive(r_r, e_r, a_r, b_r);
         step();
         full = 64'(a_r) * 64'(b_r);
         if (r_r)      model = 32'd0;
         else if (e_r) model = full[31:0];
         check($sformatf("rand%0d", i), y, model);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, want finish");
      $fatal(1);
   end

endmodule : tb_clock_gated_exact_mult_16bit

// File: doc/clock_gated_exact_mult_16bit.md
CLOCK_GATED_EXACT_MULT_16BIT -- requirements
Module: clock_gated_exact_mult_16bit

Interface
REQ-001 SHALL declare parameter N, default 16, meaning operand width; output width is 2*N; only N=16 is required to be supported.
REQ-002 SHALL have port clk, input, 1 bit: the single system clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have port en, input, 1 bit: capture enable; when low, the internal clock is gated off.
REQ-005 SHALL have port A, input, 16 bits: unsigned multiplicand.
REQ-006 SHALL have port B, input, 16 bits: unsigned multiplier.
REQ-007 SHALL have port Y, output, 32 bits: registered unsigned exact product.

Function
REQ-008 SHALL compute the exact unsigned product A*B over the full 32 bits, with no truncation or approximation of any bit.
REQ-009 SHALL build the combinational product from 16x16 AND-gate partial products summed by an array or carry-save adder tree of full/half adders, not a behavioural "*" operator.
REQ-010 SHALL drive Y from a 32-bit register clocked by the gated clock gclk.
REQ-011 SHALL load Y with A*B on a rising clk edge where rst=0 and en=1; latency is one cycle from operands valid to Y valid.
REQ-012 SHALL hold Y unchanged on every rising edge where rst=0 and en=0, regardless of A and B activity.
REQ-013 SHALL generate gclk with a glitch-free latch-based integrated clock gate:
- enable latch is transparent while clk is low;
- gclk = clk AND latched enable.
REQ-014 SHALL use (en OR rst) as the gate enable, so a synchronous reset takes effect even while en=0.
REQ-015 SHALL ensure an en change during clk high does not alter gclk until the next low phase, so no gclk glitches or truncated pulses occur.
REQ-016 SHALL have no handshake; A and B are sampled only at the enabled edge and need not be held afterwards.
REQ-017 SHALL produce 0xFFFE0001 for A=B=0xFFFF (full-range boundary), and 0 when either operand is 0.

Reset
REQ-018 SHALL set Y to 32'h0000_0000 on a rising clk edge with rst=1, independent of en.
REQ-019 SHALL give rst priority over en when both are high in the same cycle; Y=0 after that edge.
REQ-020 SHALL resume normal capture on the first enabled edge after rst deasserts.
REQ-021 SHALL keep the clock-gate latch free of reset; its state is defined by the first low phase of clk.

Structure
REQ-022 SHALL place the operand width constant (16) and product width constant (32) in the shared package mult_pkg.
REQ-023 SHALL implement the clock gate as one sub-module, clock_gate_icg, with ports clk, en, gclk; the multiplier array and output register stay in the top module.
REQ-024 SHALL keep the RTL synthesizable, with the only latch being the one inside clock_gate_icg.

Verification
REQ-025 SHALL cover this reset case: rst=1 for one edge with en=0, A=B=0, then rst=0 -> Y=0.
REQ-026 SHALL cover these enabled captures with en=1, each followed by one edge:
- A=20, B=10 -> Y=200;
- A=100, B=25 -> Y=2500;
- A=1024, B=8 -> Y=8192;
- A=5000, B=3000 -> Y=15000000 (0x00E4E1C0).
REQ-027 SHALL cover this gated hold: en=0, A=B=65535 for two edges -> Y stays 15000000 and gclk shows no pulses.
REQ-028 SHALL cover this re-enable case: en=1, A=B=15 -> Y=225 after one edge.
REQ-029 SHALL cover this boundary and priority case: en=1, A=B=0xFFFF -> Y=0xFFFE0001; then rst=1 with en=1 -> Y=0 on the next edge.
REQ-030 SHALL include a randomized self-check of 1000 operand pairs against the reference product A*B, with random en, to confirm hold and capture behaviour.
